ysyx_22040125_axi_master: RTL and testbench



---
 rtl/ysyx_22040125_axi_master_pkg.sv | 17 +
 rtl/ysyx_22040125_axi_master_if.sv | 72 +++++++
 rtl/ysyx_22040125_rr_arbiter.sv | 39 +++
 rtl/ysyx_22040125_axi_master.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_22040125_axi_master.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040125_axi_master_pkg.sv
// Shared types and AXI constants for the ysyx_22040125 AXI4 master bridge.
package ysyx_22040125_axi_master_pkg;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_B} w_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR both carry bit 1.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/ysyx_22040125_axi_master_if.sv
// AXI4 bus between the bridge (master) and the SoC/simulation memory (slave).
interface ysyx_22040125_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/ysyx_22040125_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, which moves past the winner on advance.
module ysyx_22040125_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (int'(idx) == N - 1) ? '0 : idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/ysyx_22040125_axi_master.sv
// AXI4 master bridge: N_RD round-robin read requesters and one write requester,
// independent read and write FSMs, INCR bursts up to 256 beats.
module ysyx_22040125_axi_master
  import ysyx_22040125_axi_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int N_RD   = 2
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [N_RD-1:0]        rd_req_valid,
  output logic [N_RD-1:0]        rd_req_ready,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  input  logic [N_RD*8-1:0]      rd_len,
  input  logic [N_RD*3-1:0]      rd_size,
  output logic [N_RD-1:0]        rd_beat_valid,
  output logic [DATA_W-1:0]      rd_beat_data,
  output logic                   rd_beat_last,
  output logic                   rd_err,
  input  logic                   wr_req_valid,
  output logic                   wr_req_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [7:0]             wr_len,
  input  logic [2:0]             wr_size,
  input  logic                   wr_data_valid,
  output logic                   wr_data_ready,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W/8-1:0]    wr_strb,
  output logic                   wr_done,
  output logic                   wr_err,
  ysyx_22040125_axi_master_if.master axi
);
  localparam int IDX_W = (N_RD > 1) ? $clog2(N_RD) : 1;

  r_state_e          r_state_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q, rcnt_q;
  logic [2:0]        arsize_q;
  logic [IDX_W-1:0]  port_q, rd_idx;
  logic [N_RD-1:0]   rd_grant;
  logic              arvalid_q, rerr_q, r_idle, r_data_st, beat_err;

  w_state_e          w_state_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [7:0]        awlen_q, wcnt_q;
  logic [2:0]        awsize_q;
  logic              awvalid_q, w_done_q, w_xfer, aw_hs, w_hs, w_last_hs;
  logic              unused_bid;

  assign r_idle    = (r_state_q == R_IDLE);
  assign r_data_st = (r_state_q == R_DATA);

  ysyx_22040125_rr_arbiter #(.N(N_RD), .IDX_W(IDX_W)) u_rr_arbiter (
    .clk     (aclk),
    .rst     (areset),
    .req     (rd_req_valid),
    .advance (r_idle),
    .grant   (rd_grant),
    .idx     (rd_idx)
  );

  assign rd_req_ready = (r_idle && !areset) ? rd_grant : '0;

  // Errors fold in per beat; the accumulated flag is only shown on the last beat.
  assign beat_err = resp_is_err(axi.rresp) || (axi.rid != ID_W'(port_q)) ||
                    (axi.rlast && (rcnt_q != arlen_q));

  assign rd_beat_valid = (r_data_st && axi.rvalid) ? (N_RD'(1) << port_q) : '0;
  assign rd_beat_data  = r_data_st ? axi.rdata : '0;
  assign rd_beat_last  = r_data_st && axi.rvalid && axi.rlast;
  assign rd_err        = rd_beat_last && (rerr_q || beat_err);

  assign axi.arid    = ID_W'(port_q);
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = r_data_st;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      port_q    <= '0;
      arvalid_q <= 1'b0;
      rcnt_q    <= '0;
      rerr_q    <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: if (|rd_req_valid) begin
          araddr_q  <= rd_addr[int'(rd_idx)*ADDR_W +: ADDR_W];
          arlen_q   <= rd_len[int'(rd_idx)*8 +: 8];
          arsize_q  <= rd_size[int'(rd_idx)*3 +: 3];
          port_q    <= rd_idx;
          arvalid_q <= 1'b1;
          rcnt_q    <= '0;
          rerr_q    <= 1'b0;
          r_state_q <= R_AR;
        end
        R_AR: if (axi.arready) begin
          arvalid_q <= 1'b0;
          r_state_q <= R_DATA;
        end
        R_DATA: if (axi.rvalid) begin
          rcnt_q <= rcnt_q + 8'd1;
          rerr_q <= rerr_q || beat_err;
          if (axi.rlast) begin
            rcnt_q    <= '0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign w_xfer    = (w_state_q == W_XFER);
  assign aw_hs     = awvalid_q && axi.awready;
  assign w_hs      = axi.wvalid && axi.wready;
  assign w_last_hs = w_hs && axi.wlast;

  assign wr_req_ready  = (w_state_q == W_IDLE) && !areset;
  assign wr_data_ready = w_xfer && !w_done_q && axi.wready;
  assign wr_done       = (w_state_q == W_B) && axi.bvalid;
  assign wr_err        = wr_done && resp_is_err(axi.bresp);
  assign unused_bid    = ^axi.bid;

  assign axi.awid    = '0;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = awlen_q;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;
  assign axi.wvalid  = w_xfer && !w_done_q && wr_data_valid;
  assign axi.wdata   = w_xfer ? wr_data : '0;
  assign axi.wstrb   = w_xfer ? wr_strb : '0;
  assign axi.wlast   = w_xfer && (wcnt_q == awlen_q);
  assign axi.bready  = (w_state_q == W_B);

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awvalid_q <= 1'b0;
      wcnt_q    <= '0;
      w_done_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (wr_req_valid) begin
          awaddr_q  <= wr_addr;
          awlen_q   <= wr_len;
          awsize_q  <= wr_size;
          awvalid_q <= 1'b1;
          wcnt_q    <= '0;
          w_done_q  <= 1'b0;
          w_state_q <= W_XFER;
        end
        W_XFER: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs) wcnt_q <= wcnt_q + 8'd1;
          if (w_last_hs) w_done_q <= 1'b1;
          // AW and the final W beat may complete in either order, or together.
          if ((!awvalid_q || aw_hs) && (w_done_q || w_last_hs)) w_state_q <= W_B;
        end
        W_B: if (axi.bvalid) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22040125_axi_master.sv
// Directed bench for ysyx_22040125_axi_master; the bench plays the AXI slave by hand.
module tb_ysyx_22040125_axi_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int N_RD   = 2;

  logic                   aclk = 1'b0;
  logic                   areset;
  logic [N_RD-1:0]        rd_req_valid, rd_req_ready, rd_beat_valid;
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD*8-1:0]      rd_len;
  logic [N_RD*3-1:0]      rd_size;
  logic [DATA_W-1:0]      rd_beat_data, wr_data;
  logic                   rd_beat_last, rd_err;
  logic                   wr_req_valid, wr_req_ready, wr_data_valid, wr_data_ready;
  logic [ADDR_W-1:0]      wr_addr;
  logic [7:0]             wr_len;
  logic [2:0]             wr_size;
  logic [DATA_W/8-1:0]    wr_strb;
  logic                   wr_done, wr_err;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  ysyx_22040125_axi_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  ysyx_22040125_axi_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .N_RD(N_RD)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_addr       (rd_addr),
    .rd_len        (rd_len),
    .rd_size       (rd_size),
    .rd_beat_valid (rd_beat_valid),
    .rd_beat_data  (rd_beat_data),
    .rd_beat_last  (rd_beat_last),
    .rd_err        (rd_err),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_addr       (wr_addr),
    .wr_len        (wr_len),
    .wr_size       (wr_size),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_done       (wr_done),
    .wr_err        (wr_err),
    .axi           (axi)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full read burst; port 1 sees addr, port 0 sees addr+0x100.
  task automatic rd_txn(input logic [1:0] req, input int port, input logic [7:0] len,
                        input int last_beat, input int bad_beat, input logic exp_err,
                        input logic [31:0] addr);
    logic [31:0] exp_addr;
    exp_addr     = (port == 1) ? addr : addr + 32'h100;
    rd_req_valid = req;
    rd_addr      = {addr, addr + 32'h100};
    rd_len       = {len, len};
    rd_size      = {3'd3, 3'd3};
    #1 chk("rd_req_ready", 64'(rd_req_ready), 64'(2'b01 << port));
    tick(); #1;
    chk("rd_req_ready_busy", 64'(rd_req_ready), 64'd0);
    chk("arvalid", 64'(axi.arvalid), 64'd1);
    chk("arid", 64'(axi.arid), 64'(port));
    chk("araddr", 64'(axi.araddr), 64'(exp_addr));
    chk("arlen", 64'(axi.arlen), 64'(len));
    chk("arsize", 64'(axi.arsize), 64'd3);
    chk("arburst", 64'(axi.arburst), 64'd1);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    #1 chk("rready", 64'(axi.rready), 64'd1);
    chk("arvalid_drop", 64'(axi.arvalid), 64'd0);
    for (int b = 0; b <= last_beat; b++) begin
      axi.rvalid = 1'b1;
      axi.rid    = ID_W'(port);
      axi.rdata  = {32'hcafe_0000, 32'(b)};
      axi.rlast  = (b == last_beat);
      axi.rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
      #1;
      chk("rd_beat_valid", 64'(rd_beat_valid), 64'(2'b01 << port));
      chk("rd_beat_data", rd_beat_data, {32'hcafe_0000, 32'(b)});
      chk("rd_beat_last", 64'(rd_beat_last), 64'(b == last_beat));
      if (b == last_beat) chk("rd_err", 64'(rd_err), 64'(exp_err));
      tick();
    end
    axi.rvalid   = 1'b0;
    axi.rlast    = 1'b0;
    axi.rresp    = 2'b00;
    rd_req_valid = '0;
  endtask

  initial begin
    areset        = 1'b1;
    rd_req_valid  = 2'b11;
    rd_addr       = '0;
    rd_len        = '0;
    rd_size       = '0;
    wr_req_valid  = 1'b1;
    wr_addr       = '0;
    wr_len        = '0;
    wr_size       = '0;
    wr_data_valid = 1'b0;
    wr_data       = '0;
    wr_strb       = '0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;

    // Reset state, with requests asserted to show the readies are held low.
    tick(); tick(); #1;
    chk("rst_rd_req_ready", 64'(rd_req_ready), 64'd0);
    chk("rst_wr_req_ready", 64'(wr_req_ready), 64'd0);
    chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
    chk("rst_awvalid", 64'(axi.awvalid), 64'd0);
    chk("rst_wvalid", 64'(axi.wvalid), 64'd0);
    chk("rst_rready", 64'(axi.rready), 64'd0);
    chk("rst_bready", 64'(axi.bready), 64'd0);
    chk("rst_araddr", 64'(axi.araddr), 64'd0);
    chk("rst_rd_beat_valid", 64'(rd_beat_valid), 64'd0);
    chk("rst_wr_done", 64'(wr_done), 64'd0);
    rd_req_valid = '0;
    wr_req_valid = 1'b0;
    areset       = 1'b0;
    tick();

    rd_txn(2'b10, 1, 8'd3, 3, -1, 1'b0, 32'h8000_0010);
    // Both ports asserting every transaction: strict 0,1,0,1 rotation.
    rd_txn(2'b11, 0, 8'd0, 0, -1, 1'b0, 32'h8000_0100);
    rd_txn(2'b11, 1, 8'd0, 0, -1, 1'b0, 32'h8000_0200);
    rd_txn(2'b11, 0, 8'd0, 0, -1, 1'b0, 32'h8000_0300);
    rd_txn(2'b11, 1, 8'd0, 0, -1, 1'b0, 32'h8000_0400);
    rd_txn(2'b01, 0, 8'd1, 1, 0, 1'b1, 32'h8000_0500);
    rd_txn(2'b01, 0, 8'd3, 0, -1, 1'b1, 32'h8000_0600);
    rd_txn(2'b10, 1, 8'd1, 1, -1, 1'b0, 32'h8000_0700);
    rd_txn(2'b01, 0, 8'd255, 255, -1, 1'b0, 32'h8000_0800);

    // Write len=1, awready held off for three cycles, wready immediate.
    wr_req_valid = 1'b1; wr_addr = 32'h8000_1000; wr_len = 8'd1; wr_size = 3'd3;
    #1 chk("wr_req_ready", 64'(wr_req_ready), 64'd1);
    tick();
    wr_req_valid = 1'b0; wr_data_valid = 1'b1; wr_data = 64'h1111; wr_strb = 8'hFF;
    axi.wready = 1'b1; axi.awready = 1'b0;
    #1;
    chk("awvalid", 64'(axi.awvalid), 64'd1);
    chk("awaddr", 64'(axi.awaddr), 64'h8000_1000);
    chk("awlen", 64'(axi.awlen), 64'd1);
    chk("awsize", 64'(axi.awsize), 64'd3);
    chk("wvalid_b0", 64'(axi.wvalid), 64'd1);
    chk("wlast_b0", 64'(axi.wlast), 64'd0);
    chk("wdata_b0", axi.wdata, 64'h1111);
    chk("wstrb", 64'(axi.wstrb), 64'hFF);
    chk("wr_data_ready", 64'(wr_data_ready), 64'd1);
    chk("wr_req_ready_busy", 64'(wr_req_ready), 64'd0);
    tick();
    wr_data = 64'h2222;
    #1;
    chk("wlast_b1", 64'(axi.wlast), 64'd1);
    chk("wdata_b1", axi.wdata, 64'h2222);
    tick();
    wr_data_valid = 1'b0;
    #1;
    chk("wvalid_after_last", 64'(axi.wvalid), 64'd0);
    chk("awvalid_pending", 64'(axi.awvalid), 64'd1);
    chk("bready_early", 64'(axi.bready), 64'd0);
    tick();
    axi.awready = 1'b1;
    #1 chk("awvalid_held", 64'(axi.awvalid), 64'd1);
    tick();
    axi.awready = 1'b0;
    #1;
    chk("awvalid_drop", 64'(axi.awvalid), 64'd0);
    chk("bready", 64'(axi.bready), 64'd1);
    chk("wr_done_idle", 64'(wr_done), 64'd0);
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    #1;
    chk("wr_done", 64'(wr_done), 64'd1);
    chk("wr_err_ok", 64'(wr_err), 64'd0);
    tick();
    axi.bvalid = 1'b0;
    #1;
    chk("wr_done_pulse", 64'(wr_done), 64'd0);
    chk("wr_req_ready_again", 64'(wr_req_ready), 64'd1);

    // Concurrent len=0 read and write accepted together; write gets SLVERR.
    rd_req_valid = 2'b01; rd_len = '0; rd_addr = {32'h0, 32'h8000_3000};
    wr_req_valid = 1'b1; wr_len = 8'd0; wr_addr = 32'h8000_2000;
    #1;
    chk("cc_rd_req_ready", 64'(rd_req_ready), 64'd1);
    chk("cc_wr_req_ready", 64'(wr_req_ready), 64'd1);
    tick();
    rd_req_valid = '0; wr_req_valid = 1'b0;
    #1;
    chk("cc_arvalid", 64'(axi.arvalid), 64'd1);
    chk("cc_awvalid", 64'(axi.awvalid), 64'd1);
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    wr_data_valid = 1'b1; wr_data = 64'h3333;
    #1;
    chk("cc_wlast", 64'(axi.wlast), 64'd1);
    chk("cc_wvalid", 64'(axi.wvalid), 64'd1);
    tick();
    axi.arready = 1'b0; axi.awready = 1'b0; wr_data_valid = 1'b0;
    axi.rvalid = 1'b1; axi.rid = '0; axi.rlast = 1'b1; axi.rdata = 64'h4444; axi.rresp = 2'b00;
    axi.bvalid = 1'b1; axi.bresp = 2'b10;
    #1;
    chk("cc_rd_beat_valid", 64'(rd_beat_valid), 64'd1);
    chk("cc_rd_beat_last", 64'(rd_beat_last), 64'd1);
    chk("cc_rd_beat_data", rd_beat_data, 64'h4444);
    chk("cc_rd_err", 64'(rd_err), 64'd0);
    chk("cc_wr_done", 64'(wr_done), 64'd1);
    chk("cc_wr_err", 64'(wr_err), 64'd1);
    tick();
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    #1;
    chk("cc_wr_done_pulse", 64'(wr_done), 64'd0);
    chk("cc_rready_idle", 64'(axi.rready), 64'd0);
    chk("cc_bready_idle", 64'(axi.bready), 64'd0);

    // Reset while the read is in R_DATA and the write in W_XFER; port 0 wins so rr_ptr=1.
    rd_req_valid = 2'b01; rd_len = {8'd3, 8'd3};
    wr_req_valid = 1'b1; wr_len = 8'd3;
    tick();
    rd_req_valid = '0; wr_req_valid = 1'b0;
    axi.arready = 1'b1; axi.awready = 1'b0; axi.wready = 1'b0; wr_data_valid = 1'b1;
    tick();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rid = '0; axi.rlast = 1'b0; axi.rdata = 64'h5555;
    #1;
    chk("mid_rready", 64'(axi.rready), 64'd1);
    chk("mid_rd_beat_valid", 64'(rd_beat_valid), 64'd1);
    chk("mid_wvalid", 64'(axi.wvalid), 64'd1);
    chk("mid_awvalid", 64'(axi.awvalid), 64'd1);
    areset = 1'b1;
    tick();
    rd_req_valid = 2'b11; wr_req_valid = 1'b1;
    #1;
    chk("rst2_arvalid", 64'(axi.arvalid), 64'd0);
    chk("rst2_awvalid", 64'(axi.awvalid), 64'd0);
    chk("rst2_wvalid", 64'(axi.wvalid), 64'd0);
    chk("rst2_rready", 64'(axi.rready), 64'd0);
    chk("rst2_rd_beat_valid", 64'(rd_beat_valid), 64'd0);
    chk("rst2_rd_beat_data", rd_beat_data, 64'd0);
    chk("rst2_rd_req_ready", 64'(rd_req_ready), 64'd0);
    chk("rst2_wr_req_ready", 64'(wr_req_ready), 64'd0);
    axi.rvalid = 1'b0; wr_data_valid = 1'b0;
    areset = 1'b0;
    #1;
    chk("rel_rd_req_ready", 64'(rd_req_ready), 64'd1);
    chk("rel_wr_req_ready", 64'(wr_req_ready), 64'd1);
    rd_req_valid = '0; wr_req_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
